// File: rtl/pht_gshare.sv
// Gshare pattern-history table: saturating direction counters indexed by PC index XOR history,
// with a speculative GHR, misprediction recovery and a forwarding read-modify-write update path.
module pht_gshare #(
   parameter int ENTRIES  = 256,
   parameter int CTR_W    = 2,
   parameter int RD_PORTS = 2,
   parameter int GHR_W    = 8,
   localparam int IDX_W   = $clog2(ENTRIES),
   parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'(2**(CTR_W-1) - 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RD_PORTS*IDX_W-1:0] i_rd_index,
   output logic [RD_PORTS-1:0]       o_taken_or_not,
   output logic [GHR_W-1:0]          o_ghr,
   input  logic                      i_spec_en,
   input  logic                      i_spec_taken,
   input  logic                      i_update_en,
   input  logic [IDX_W-1:0]          i_update_index,
   input  logic [GHR_W-1:0]          i_update_ghr,
   input  logic                      i_taken_actual,
   input  logic                      i_mispredict,
   output logic                      o_init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_run;
   logic [IDX_W-1:0]     r_sweep_cnt;
   logic [CTR_W-1:0]     r_mem [ENTRIES];
   logic [GHR_W-1:0]     r_ghr;
   logic [GHR_W-1:0]     w_ghr_spec;
   logic [GHR_W-1:0]     w_ghr_rec;
   logic [RD_PORTS-1:0]  r_taken_or_not;
   logic [RD_PORTS-1:0]  w_rd_bit;

   logic                 r_u2_valid;
   logic [IDX_W-1:0]     r_u2_idx;
   logic                 r_u2_taken;
   logic [CTR_W-1:0]     r_u2_old;
   logic [CTR_W-1:0]     w_u2_new;
   logic [IDX_W-1:0]     w_u1_idx;
   logic [CTR_W-1:0]     w_u1_old;

   logic                 w_wr_en;
   logic [IDX_W-1:0]     w_wr_idx;
   logic [CTR_W-1:0]     w_wr_data;

   function automatic logic [CTR_W-1:0] f_next_ctr(input logic [CTR_W-1:0] c, input logic t);
      logic [CTR_W-1:0] n;
      n = c;
      if (t && (c != '1))
         n = c + 1'b1;
      else if (!t && (c != '0))
         n = c - 1'b1;
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_INIT;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if ((r_state == ST_INIT) && (r_sweep_cnt == IDX_W'(ENTRIES - 1)))
         w_state_next = ST_RUN;
   end

   assign w_run       = (r_state == ST_RUN);
   assign o_init_done = w_run;

   always_ff @(posedge clk) begin
      if (rst)
         r_sweep_cnt <= '0;
      else if (!w_run)
         r_sweep_cnt <= r_sweep_cnt + 1'b1;
   end

   // U1 forwards the value U2 is writing this cycle so back-to-back updates never read stale data.
   assign w_u1_idx = i_update_index ^ IDX_W'(i_update_ghr);
   assign w_u2_new = f_next_ctr(r_u2_old, r_u2_taken);
   assign w_u1_old = (r_u2_valid && (r_u2_idx == w_u1_idx)) ? w_u2_new : r_mem[w_u1_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_u2_valid <= 1'b0;
         r_u2_idx   <= '0;
         r_u2_taken <= 1'b0;
         r_u2_old   <= '0;
      end else begin
         r_u2_valid <= w_run && i_update_en;
         r_u2_idx   <= w_u1_idx;
         r_u2_taken <= i_taken_actual;
         r_u2_old   <= w_u1_old;
      end
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = r_sweep_cnt;
      w_wr_data = INIT_VAL;
      if (!rst) begin
         if (!w_run) begin
            w_wr_en = 1'b1;
         end else if (r_u2_valid) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_u2_idx;
            w_wr_data = w_u2_new;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[w_wr_idx] <= w_wr_data;
   end

   generate
      if (GHR_W == 1) begin : g_ghr_one
         assign w_ghr_spec = i_spec_taken;
         assign w_ghr_rec  = i_taken_actual;
      end else begin : g_ghr_shift
         assign w_ghr_spec = {r_ghr[GHR_W-2:0], i_spec_taken};
         assign w_ghr_rec  = {i_update_ghr[GHR_W-2:0], i_taken_actual};
      end
   endgenerate

   // Recovery from a misprediction overrides any speculative shift in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         r_ghr <= '0;
      else if (w_run) begin
         if (i_update_en && i_mispredict)
            r_ghr <= w_ghr_rec;
         else if (i_spec_en)
            r_ghr <= w_ghr_spec;
      end
   end

   assign o_ghr = r_ghr;

   generate
      for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
         logic [IDX_W-1:0] w_rd_idx;
         assign w_rd_idx = i_rd_index[p*IDX_W +: IDX_W] ^ IDX_W'(r_ghr);
         assign w_rd_bit[p] = (r_u2_valid && (r_u2_idx == w_rd_idx)) ? w_u2_new[CTR_W-1]
                                                                       : r_mem[w_rd_idx][CTR_W-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || !w_run)
         r_taken_or_not <= '0;
      else
         r_taken_or_not <= w_rd_bit;
   end

   assign o_taken_or_not = r_taken_or_not;

endmodule

// File: doc/pht_gshare.md
# pht_gshare

Parametrised gshare pattern-history table, the successor to the fixed 256×2-bit PHT in the front-end BPU. It holds saturating direction counters indexed by PC-index XOR global history, serves RD_PORTS predictions per cycle, and owns the speculative global history register (GHR) with misprediction recovery. Counter updates go through a two-stage read-modify-write pipeline with forwarding so that back-to-back updates to the same entry never use stale data. A post-reset init sweep makes the array block-RAM friendly, since no single-cycle array reset is required.

## Interface
- ENTRIES, 256, table depth; power of 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, counter width, ≥2.
- RD_PORTS, 2, number of prediction read ports.
- GHR_W, 8, history length, 1..IDX_W.
- INIT_VAL, 2**(CTR_W-1)-1, post-reset counter value (weakly not-taken).
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- rd_index  in  RD_PORTS×IDX_W  per-port PC index (unhashed).
- taken_or_not  out  RD_PORTS  predicted direction (counter MSB), registered.
- ghr  out  GHR_W  current speculative GHR; fetch snapshots it alongside each prediction.
- spec_en  in  1  shift a speculative outcome into GHR.
- spec_taken  in  1  outcome shifted by spec_en.
- update_en  in  1  commit-time counter update.
- update_index  in  IDX_W  unhashed PC index of the resolved branch.
- update_ghr  in  GHR_W  GHR snapshot taken at prediction time.
- taken_actual  in  1  resolved direction.
- mispredict  in  1  with update_en: restore GHR.
- init_done  out  1  table initialised; predictions and updates are valid.

## Operation
- Hash: h(idx, g) = idx XOR zero-extend(g) to IDX_W. Reads use the live ghr; updates use update_ghr.
- FSM states:
  - INIT: entered on rst. Writes INIT_VAL to entry sweep_cnt and increments sweep_cnt each cycle. Moves to RUN after entry ENTRIES-1 is written.
  - RUN: normal operation. No exit except rst.
- In INIT: taken_or_not is forced to 0; update_en, spec_en and mispredict are ignored.
- Counter arithmetic: taken → min(c+1, 2^CTR_W-1); not taken → max(c-1, 0). No wrap.
- Update pipeline:
  - U1 (cycle T): capture hashed index and taken_actual; issue array read.
  - U2 (cycle T+1): compute the new counter and write it at the end of T+1.
  - Forwarding: if the U2 entry being written equals the U1 entry being read, U1 uses U2's new value instead of the array data.
  - Result: consecutive-cycle updates to one entry accumulate exactly.
- Read ports: sample the array at T; output at T+1. If U2 writes the same entry during T, the port returns the newly written value (write-first bypass). Ports are independent; duplicate indices are allowed.
- GHR:
  - Priority: recovery > speculative.
  - Recovery (update_en && mispredict in RUN): ghr ← {update_ghr[GHR_W-2:0], taken_actual}.
  - Speculative, otherwise if spec_en: ghr ← {ghr[GHR_W-2:0], spec_taken}.
  - When GHR_W=1, the shift yields just the new bit.

## Timing
- Reset values: taken_or_not=0, ghr=0, init_done=0, sweep_cnt=0, U1/U2 valid=0.
- Init: the first cycle with rst low writes entry 0. init_done=1 from the ENTRIES-th cycle after rst deasserts (cycle 256 for defaults).
- rst asserted at any time (mid-sweep or in RUN) restarts the sweep at entry 0 and clears GHR and the pipeline. Any in-flight U2 write is dropped.
- Prediction latency: 1 cycle from rd_index to taken_or_not.
- Update latency: the counter is written 2 edges after update_en and is visible to a read issued in the second cycle via bypass.
- GHR changes on the edge after spec_en/mispredict. A read in the same cycle hashes with the old ghr.
- Throughput: one update and RD_PORTS reads per cycle, with no stalls.

## Test plan
- Init sweep: deassert rst, count cycles → init_done rises at cycle 256. Every read then returns 0; a backdoor check shows every entry = 1.
- Training: ghr=0, update index 0x12 taken twice on separate cycles, then read 0x12 → taken_or_not=1. Two further taken updates leave the counter at 3. Four not-taken updates → 0, and a fifth stays at 0.
- Back-to-back forwarding: four consecutive-cycle taken updates to 0x40 from state 0 → counter=3, not 1. A read of 0x40 issued in the same cycle as the final write returns 1.
- GHR: spec_en with taken=1,0,1 → ghr=0x05. Then, in one cycle, spec_en=1 plus update_en with mispredict=1, update_ghr=0x80, taken_actual=0 → ghr=0x00 (recovery wins).
- Hashing: ghr=0x0F, train index 0x0F taken to 3 via update_ghr=0x0F, then read rd_index=0x0F → 1. Read with ghr=0x00 → 0.
- Reset mid-operation: assert rst during sweep entry 100 and again during an active update → init_done=0, ghr=0, and the sweep restarts and completes 256 cycles later. The dropped update is not visible.
